// File: rtl/mc_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// producing Moore-decoded datapath controls with mem_rdy/zero-qualified PC and IR loads.
module mc_ctrl (
    input  logic       clk,
    input  logic       rstn,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_rdy,
    output logic       mem_re,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       reg_we,
    output logic       reg_dst,
    output logic       wd_sel,
    output logic       ext_op,
    output logic       alu_srca,
    output logic [1:0] alu_srcb,
    output logic [2:0] alu_op,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_IEXEC  = 4'd9,
        S_IWB    = 4'd10,
        S_BRANCH = 4'd11,
        S_JUMP   = 4'd12
    } state_t;

    localparam logic [2:0] ALU_NOP  = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_OR   = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t     r_state;
    state_t     w_next;
    logic [2:0] w_functOp;
    logic       w_functLegal;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // R-type funct decode, shared by the DECODE legality check and EXEC.
    always_comb begin
        w_functLegal = 1'b1;
        w_functOp    = ALU_NOP;
        case (funct)
            6'b100000: w_functOp = ALU_ADD;
            6'b100010: w_functOp = ALU_SUB;
            6'b100100: w_functOp = ALU_AND;
            6'b100101: w_functOp = ALU_OR;
            6'b101010: w_functOp = ALU_SLT;
            6'b101011: w_functOp = ALU_SLTU;
            default:   w_functLegal = 1'b0;
        endcase
    end

    always_comb begin
        w_next   = S_IDLE;
        mem_re   = 1'b0;
        mem_we   = 1'b0;
        iord     = 1'b0;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        pc_src   = 2'b00;
        reg_we   = 1'b0;
        reg_dst  = 1'b0;
        wd_sel   = 1'b0;
        ext_op   = 1'b0;
        alu_srca = 1'b0;
        alu_srcb = 2'b00;
        alu_op   = ALU_NOP;
        illegal  = 1'b0;
        case (r_state)
            S_IDLE: w_next = S_FETCH;
            S_FETCH: begin
                mem_re   = 1'b1;
                alu_srcb = 2'b01;
                alu_op   = ALU_ADD;
                ir_we    = mem_rdy;
                pc_we    = mem_rdy;
                w_next   = mem_rdy ? S_DECODE : S_FETCH;
            end
            // Branch target is precomputed here while the opcode is examined.
            S_DECODE: begin
                alu_srcb = 2'b11;
                ext_op   = 1'b1;
                alu_op   = ALU_ADD;
                w_next   = S_FETCH;
                case (op)
                    OP_RTYPE: begin
                        if (w_functLegal) w_next = S_EXEC;
                        else              illegal = 1'b1;
                    end
                    OP_LW, OP_SW:     w_next = S_MEMADR;
                    OP_ADDI, OP_ORI:  w_next = S_IEXEC;
                    OP_BEQ:           w_next = S_BRANCH;
                    OP_J:             w_next = S_JUMP;
                    default:          illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alu_srca = 1'b1;
                alu_srcb = 2'b10;
                ext_op   = 1'b1;
                alu_op   = ALU_ADD;
                w_next   = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_re = 1'b1;
                iord   = 1'b1;
                w_next = mem_rdy ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                reg_we = 1'b1;
                wd_sel = 1'b1;
                w_next = S_FETCH;
            end
            S_MEMWR: begin
                mem_we = 1'b1;
                iord   = 1'b1;
                w_next = mem_rdy ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                alu_srca = 1'b1;
                alu_op   = w_functOp;
                w_next   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_we  = 1'b1;
                reg_dst = 1'b1;
                w_next  = S_FETCH;
            end
            S_IEXEC: begin
                alu_srca = 1'b1;
                alu_srcb = 2'b10;
                ext_op   = (op == OP_ADDI);
                alu_op   = (op == OP_ADDI) ? ALU_ADD : ALU_OR;
                w_next   = S_IWB;
            end
            S_IWB: begin
                reg_we = 1'b1;
                w_next = S_FETCH;
            end
            S_BRANCH: begin
                alu_srca = 1'b1;
                alu_op   = ALU_SUB;
                pc_src   = 2'b01;
                pc_we    = zero;
                w_next   = S_FETCH;
            end
            S_JUMP: begin
                pc_src = 2'b10;
                pc_we  = 1'b1;
                w_next = S_FETCH;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign state = r_state;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: each cycle's expected control vector is queued
// when stimulus is driven and popped/compared at the following falling edge.
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [5:0] op = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       mem_rdy = 1'b0;
    logic       mem_re, mem_we, iord, ir_we, pc_we, reg_we, reg_dst, wd_sel;
    logic       ext_op, alu_srca, illegal;
    logic [1:0] pc_src, alu_srcb;
    logic [2:0] alu_op;
    logic [3:0] state;

    int testCount = 0;
    int failCount = 0;

    logic [21:0] expQ[$];
    string       tagQ[$];

    mc_ctrl dut (
        .clk(clk), .rstn(rstn), .op(op), .funct(funct), .zero(zero), .mem_rdy(mem_rdy),
        .mem_re(mem_re), .mem_we(mem_we), .iord(iord), .ir_we(ir_we), .pc_we(pc_we),
        .pc_src(pc_src), .reg_we(reg_we), .reg_dst(reg_dst), .wd_sel(wd_sel),
        .ext_op(ext_op), .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_op(alu_op),
        .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    // Output bundle: {state, mem_re, mem_we, iord, ir_we, pc_we, pc_src, reg_we,
    // reg_dst, wd_sel, ext_op, srca, srcb, alu_op, illegal}.
    localparam logic [21:0] ILL       = 22'd1 << 0;
    localparam logic [21:0] ALU_ADD   = 22'd1 << 1;
    localparam logic [21:0] ALU_SUB   = 22'd2 << 1;
    localparam logic [21:0] ALU_OR    = 22'd4 << 1;
    localparam logic [21:0] SRCB_4    = 22'd1 << 4;
    localparam logic [21:0] SRCB_IMM  = 22'd2 << 4;
    localparam logic [21:0] SRCB_SH   = 22'd3 << 4;
    localparam logic [21:0] SRCA      = 22'd1 << 6;
    localparam logic [21:0] EXT       = 22'd1 << 7;
    localparam logic [21:0] WDSEL     = 22'd1 << 8;
    localparam logic [21:0] REGDST    = 22'd1 << 9;
    localparam logic [21:0] REGWE     = 22'd1 << 10;
    localparam logic [21:0] PCS_AOUT  = 22'd1 << 11;
    localparam logic [21:0] PCS_JMP   = 22'd2 << 11;
    localparam logic [21:0] PCWE      = 22'd1 << 13;
    localparam logic [21:0] IRWE      = 22'd1 << 14;
    localparam logic [21:0] IORD      = 22'd1 << 15;
    localparam logic [21:0] MWE       = 22'd1 << 16;
    localparam logic [21:0] MRE       = 22'd1 << 17;

    localparam logic [21:0] ST_IDLE   = 22'd0  << 18;
    localparam logic [21:0] ST_FETCH  = 22'd1  << 18;
    localparam logic [21:0] ST_DECODE = 22'd2  << 18;
    localparam logic [21:0] ST_MEMADR = 22'd3  << 18;
    localparam logic [21:0] ST_MEMRD  = 22'd4  << 18;
    localparam logic [21:0] ST_MEMWB  = 22'd5  << 18;
    localparam logic [21:0] ST_MEMWR  = 22'd6  << 18;
    localparam logic [21:0] ST_EXEC   = 22'd7  << 18;
    localparam logic [21:0] ST_ALUWB  = 22'd8  << 18;
    localparam logic [21:0] ST_IEXEC  = 22'd9  << 18;
    localparam logic [21:0] ST_IWB    = 22'd10 << 18;
    localparam logic [21:0] ST_BRANCH = 22'd11 << 18;
    localparam logic [21:0] ST_JUMP   = 22'd12 << 18;

    localparam logic [21:0] E_FETCH   = ST_FETCH | MRE | SRCB_4 | ALU_ADD | IRWE | PCWE;
    localparam logic [21:0] E_STALL   = ST_FETCH | MRE | SRCB_4 | ALU_ADD;
    localparam logic [21:0] E_DECODE  = ST_DECODE | SRCB_SH | EXT | ALU_ADD;

    logic [21:0] observed;
    assign observed = {state, mem_re, mem_we, iord, ir_we, pc_we, pc_src, reg_we,
                       reg_dst, wd_sel, ext_op, alu_srca, alu_srcb, alu_op, illegal};

    task automatic applyStimulus(input logic [5:0] iOp, input logic [5:0] iFunct,
                                 input logic iZero, input logic iRdy,
                                 input logic [21:0] expVec, input string tag);
        op      = iOp;
        funct   = iFunct;
        zero    = iZero;
        mem_rdy = iRdy;
        expQ.push_back(expVec);
        tagQ.push_back(tag);
    endtask

    task automatic compareNow();
        logic [21:0] expVec;
        string       tag;
        testCount++;
        if (expQ.size() == 0) begin
            failCount++;
            $error("FAIL scoreboard_empty: observed %h required a queued entry", observed);
        end else begin
            expVec = expQ.pop_front();
            tag    = tagQ.pop_front();
            assert (observed === expVec) else begin
                failCount++;
                $error("FAIL %s: observed %h expected %h", tag, observed, expVec);
            end
        end
    endtask

    task automatic checkOutput();
        @(negedge clk);
        compareNow();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic [5:0] iOp, input logic [5:0] iFunct,
                       input logic iZero, input logic iRdy,
                       input logic [21:0] expVec, input string tag);
        applyStimulus(iOp, iFunct, iZero, iRdy, expVec, tag);
        checkOutput();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        @(posedge clk);
        @(posedge clk);
        #1;
        // Held in reset: everything zero even with mem_rdy high.
        cyc(6'b000000, 6'b100010, 1'b0, 1'b1, ST_IDLE, "reset_hold");
        rstn = 1'b1;
        // R-type SUB, no stalls.
        cyc(6'b000000, 6'b100010, 1'b0, 1'b1, ST_IDLE, "rt_idle");
        cyc(6'b000000, 6'b100010, 1'b0, 1'b1, E_FETCH, "rt_fetch");
        cyc(6'b000000, 6'b100010, 1'b0, 1'b1, E_DECODE, "rt_decode");
        cyc(6'b000000, 6'b100010, 1'b0, 1'b1, ST_EXEC | SRCA | ALU_SUB, "rt_exec_sub");
        cyc(6'b000000, 6'b100010, 1'b0, 1'b1, ST_ALUWB | REGWE | REGDST, "rt_aluwb");
        // lw with two read stalls, plus one fetch stall first.
        cyc(6'b100011, 6'b000000, 1'b0, 1'b0, E_STALL, "lw_fetch_stall");
        cyc(6'b100011, 6'b000000, 1'b0, 1'b1, E_FETCH, "lw_fetch");
        cyc(6'b100011, 6'b000000, 1'b0, 1'b1, E_DECODE, "lw_decode");
        cyc(6'b100011, 6'b000000, 1'b0, 1'b1, ST_MEMADR | SRCA | SRCB_IMM | EXT | ALU_ADD, "lw_memadr");
        cyc(6'b100011, 6'b000000, 1'b0, 1'b0, ST_MEMRD | MRE | IORD, "lw_memrd_s1");
        cyc(6'b100011, 6'b000000, 1'b0, 1'b0, ST_MEMRD | MRE | IORD, "lw_memrd_s2");
        cyc(6'b100011, 6'b000000, 1'b0, 1'b1, ST_MEMRD | MRE | IORD, "lw_memrd_done");
        cyc(6'b100011, 6'b000000, 1'b0, 1'b1, ST_MEMWB | REGWE | WDSEL, "lw_memwb");
        // beq taken then not taken.
        cyc(6'b000100, 6'b000000, 1'b1, 1'b1, E_FETCH, "beq1_fetch");
        cyc(6'b000100, 6'b000000, 1'b1, 1'b1, E_DECODE, "beq1_decode");
        cyc(6'b000100, 6'b000000, 1'b1, 1'b1, ST_BRANCH | SRCA | ALU_SUB | PCS_AOUT | PCWE, "beq_taken");
        cyc(6'b000100, 6'b000000, 1'b0, 1'b1, E_FETCH, "beq0_fetch");
        cyc(6'b000100, 6'b000000, 1'b0, 1'b1, E_DECODE, "beq0_decode");
        cyc(6'b000100, 6'b000000, 1'b0, 1'b1, ST_BRANCH | SRCA | ALU_SUB | PCS_AOUT, "beq_not_taken");
        // Jump.
        cyc(6'b000010, 6'b000000, 1'b0, 1'b1, E_FETCH, "j_fetch");
        cyc(6'b000010, 6'b000000, 1'b0, 1'b1, E_DECODE, "j_decode");
        cyc(6'b000010, 6'b000000, 1'b0, 1'b1, ST_JUMP | PCS_JMP | PCWE, "j_jump");
        // ori then addi.
        cyc(6'b001101, 6'b000000, 1'b0, 1'b1, E_FETCH, "ori_fetch");
        cyc(6'b001101, 6'b000000, 1'b0, 1'b1, E_DECODE, "ori_decode");
        cyc(6'b001101, 6'b000000, 1'b0, 1'b1, ST_IEXEC | SRCA | SRCB_IMM | ALU_OR, "ori_iexec");
        cyc(6'b001101, 6'b000000, 1'b0, 1'b1, ST_IWB | REGWE, "ori_iwb");
        cyc(6'b001000, 6'b000000, 1'b0, 1'b1, E_FETCH, "addi_fetch");
        cyc(6'b001000, 6'b000000, 1'b0, 1'b1, E_DECODE, "addi_decode");
        cyc(6'b001000, 6'b000000, 1'b0, 1'b1, ST_IEXEC | SRCA | SRCB_IMM | EXT | ALU_ADD, "addi_iexec");
        cyc(6'b001000, 6'b000000, 1'b0, 1'b1, ST_IWB | REGWE, "addi_iwb");
        // Illegal opcode, then illegal R-type funct.
        cyc(6'b111111, 6'b000000, 1'b0, 1'b1, E_FETCH, "ill_op_fetch");
        cyc(6'b111111, 6'b000000, 1'b0, 1'b1, E_DECODE | ILL, "ill_op_decode");
        cyc(6'b000000, 6'b000111, 1'b0, 1'b1, E_FETCH, "ill_fn_fetch");
        cyc(6'b000000, 6'b000111, 1'b0, 1'b1, E_DECODE | ILL, "ill_fn_decode");
        // sw stalled in MEMWR, reset asserted mid-cycle.
        cyc(6'b101011, 6'b000000, 1'b0, 1'b1, E_FETCH, "sw_fetch");
        cyc(6'b101011, 6'b000000, 1'b0, 1'b1, E_DECODE, "sw_decode");
        cyc(6'b101011, 6'b000000, 1'b0, 1'b1, ST_MEMADR | SRCA | SRCB_IMM | EXT | ALU_ADD, "sw_memadr");
        cyc(6'b101011, 6'b000000, 1'b0, 1'b0, ST_MEMWR | MWE | IORD, "sw_memwr_s1");
        applyStimulus(6'b101011, 6'b000000, 1'b0, 1'b0, ST_MEMWR | MWE | IORD, "sw_memwr_s2");
        @(negedge clk);
        compareNow();
        #2;
        rstn = 1'b0;
        #1;
        applyStimulus(6'b101011, 6'b000000, 1'b0, 1'b0, ST_IDLE, "sw_async_reset");
        compareNow();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        cyc(6'b101011, 6'b000000, 1'b0, 1'b1, ST_IDLE, "post_rst_idle");
        cyc(6'b101011, 6'b000000, 1'b0, 1'b1, E_FETCH, "post_rst_fetch");

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
